seq_scan_ctrl: RTL and testbench

Stream-scanning controller for the serial `1101` pattern detector. It accepts parallel words over a valid/ready handshake and serializes them MSB-first into a gated Mealy detector core at one bit per clock. It counts overlapping pattern matches per frame and reports the frame total when the word flagged `in_last` has fully drained. It sits between a word-wide producer and the bit-serial detection datapath.

---
 rtl/seq_scan_pkg.sv | 26 ++
 rtl/seq_detect_core.sv | 38 +++
 rtl/seq_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_seq_scan_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_scan_pkg
// Purpose  : Shared state encodings and the target bit pattern for the scanner.
// Revision : 1.0 - initial release
// ============================================================================
package seq_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } scan_state_t;

    // Each state names the longest pattern prefix seen so far.
    typedef enum logic [1:0] {
        DS_START = 2'd0,
        DS_1     = 2'd1,
        DS_11    = 2'd2,
        DS_110   = 2'd3
    } det_state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage
`default_nettype wire

// File: rtl/seq_detect_core.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_core
// Purpose  : Gated Mealy detector for the overlapping serial pattern 1101.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_core
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic din,
    output logic y
);

    det_state_t r_state;

    assign y = en && (r_state == DS_110) && (din == PATTERN[0]);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= DS_START;
        end else if (en) begin
            case (r_state)
                DS_START: r_state <= (din == PATTERN[3]) ? DS_1   : DS_START;
                DS_1:     r_state <= (din == PATTERN[2]) ? DS_11  : DS_START;
                DS_11:    r_state <= (din == PATTERN[1]) ? DS_110 : DS_11;
                // A completed match leaves a trailing 1 as the next prefix.
                DS_110:   r_state <= (din == PATTERN[0]) ? DS_1   : DS_START;
                default:  r_state <= DS_START;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_scan_ctrl
// Purpose  : Serializes handshaked words into the 1101 detector, counts frames.
// Revision : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat,
    output logic              done,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int              IDX_W     = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    scan_state_t        r_state;
    logic [WORD_W-1:0]  r_shift;
    logic [IDX_W-1:0]   r_bit_idx;
    logic               r_last;
    logic               r_match_pulse;
    logic               r_cnt_sat;
    logic               r_done;
    logic [CNT_W-1:0]   r_match_cnt;
    logic [CNT_W-1:0]   r_done_cnt;

    logic               w_en;
    logic               w_clr;
    logic               w_y;
    logic               w_last_bit;
    logic               w_accept;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_sat_next;

    assign w_en       = (r_state == ST_SHIFT);
    assign w_clr      = (r_state == ST_DONE);
    assign w_last_bit = (r_bit_idx == '0);
    assign in_ready   = (r_state == ST_IDLE) || (w_en && w_last_bit && !r_last);
    assign w_accept   = in_valid && in_ready;

    seq_detect_core u_core (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (w_clr),
        .din (r_shift[WORD_W-1]),
        .y   (w_y)
    );

    // Next count is shared by the running counter and the frame snapshot,
    // so a match on the final bit is included in done_cnt.
    always_comb begin
        w_cnt_next = r_match_cnt;
        w_sat_next = r_cnt_sat;
        if (w_y) begin
            if (r_match_cnt == c_CNT_MAX) begin
                w_sat_next = 1'b1;
            end else begin
                w_cnt_next = r_match_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_last        <= 1'b0;
            r_match_pulse <= 1'b0;
            r_cnt_sat     <= 1'b0;
            r_done        <= 1'b0;
            r_match_cnt   <= '0;
            r_done_cnt    <= '0;
        end else begin
            r_match_pulse <= w_y;
            r_done        <= 1'b0;
            r_match_cnt   <= w_cnt_next;
            r_cnt_sat     <= w_sat_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= in_data;
                        r_last    <= in_last;
                        r_bit_idx <= IDX_W'(WORD_W - 1);
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!w_last_bit) begin
                        r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
                        r_bit_idx <= r_bit_idx - 1'b1;
                    end else if (w_accept) begin
                        r_shift   <= in_data;
                        r_last    <= in_last;
                        r_bit_idx <= IDX_W'(WORD_W - 1);
                    end else if (r_last) begin
                        r_done     <= 1'b1;
                        r_done_cnt <= w_cnt_next;
                        r_state    <= ST_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_match_cnt <= '0;
                    r_cnt_sat   <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign match_pulse = r_match_pulse;
    assign match_cnt   = r_match_cnt;
    assign cnt_sat     = r_cnt_sat;
    assign done        = r_done;
    assign done_cnt    = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_scan_ctrl
// Purpose  : Scoreboard bench for seq_scan_ctrl (16-bit words, 8- and 2-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_scan_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [W-1:0] in_data = '0;

    logic       in_ready, busy, match_pulse, cnt_sat, done;
    logic [7:0] match_cnt, done_cnt;
    logic       in_ready_s, busy_s, match_pulse_s, cnt_sat_s, done_s;
    logic [1:0] match_cnt_s, done_cnt_s;

    seq_scan_ctrl #(.WORD_W(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .busy(busy),
        .match_pulse(match_pulse), .match_cnt(match_cnt), .cnt_sat(cnt_sat),
        .done(done), .done_cnt(done_cnt)
    );

    seq_scan_ctrl #(.WORD_W(W), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last), .busy(busy_s),
        .match_pulse(match_pulse_s), .match_cnt(match_cnt_s), .cnt_sat(cnt_sat_s),
        .done(done_s), .done_cnt(done_cnt_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int cnt;} done_exp_t;

    int        checks = 0;
    int        errors = 0;
    int        exp_match_q[$];
    done_exp_t exp_done_q[$];
    done_exp_t mon_e;
    logic [3:0] m_hist = '0;
    int        m_nb = 0;
    logic      prev_done = 1'b0;
    int        rdy_cnt = 0;
    bit        rdy_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT reports a match or a frame end.
    always @(negedge clk) begin
        if (prev_done) begin
            check("match_cnt_cleared_after_done", match_cnt, 0);
            check("cnt_sat_cleared_after_done", cnt_sat, 0);
        end
        prev_done = (done === 1'b1);
        if (rdy_en && in_ready === 1'b1) rdy_cnt++;
        if (match_pulse === 1'b1) begin
            if (exp_match_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_match: match_pulse=1 at cycle %0d, expected 0", cyc);
            end else begin
                check("match_cycle", cyc, exp_match_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected 0", cyc);
            end else begin
                mon_e = exp_done_q.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("done_cnt", done_cnt, mon_e.cnt);
            end
        end
    end

    // Presents one word, waits (bounded) for acceptance and records the expected
    // matches from a sliding 4-bit window over the frame's bit stream.
    task automatic send(input logic [W-1:0] d, input logic l, input int exp_done,
                        input int abort_bit, output int k);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
            in_valid = 1'b0;
            k = -1;
            return;
        end
        k = cyc + 1;
        for (int j = 0; j < W; j++) begin
            if (j < abort_bit) begin
                m_hist = {m_hist[2:0], d[W-1-j]};
                m_nb++;
                if (m_nb >= 4 && m_hist == 4'b1101) exp_match_q.push_back(k + 1 + j);
            end
        end
        if (abort_bit < W) begin
            m_hist = '0; m_nb = 0;
        end else if (l) begin
            exp_done_q.push_back('{k + W, exp_done});
            m_hist = '0; m_nb = 0;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_match_pulse"}, match_pulse, 0);
        check({tag, "_cnt_sat"}, cnt_sat, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_match_cnt"}, match_cnt, 0);
        check({tag, "_done_cnt"}, done_cnt, 0);
    endtask

    initial begin
        int k1, k2, k3, k4;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single last word: three overlapping matches, total 3.
        send(16'hDBA0, 1'b1, 3, W, k1);
        repeat (W + 4) @(negedge clk);

        // Cross-word match with no idle bubble between words.
        send(16'h0001, 1'b0, 0, W, k1);
        send(16'hA000, 1'b1, 1, W, k2);
        check("no_bubble_accept_gap", k2 - k1, W);
        repeat (W + 4) @(negedge clk);

        // Same words as separate frames: boundary breaks the overlap.
        send(16'h0001, 1'b1, 0, W, k1);
        send(16'hA000, 1'b1, 0, W, k2);
        repeat (W + 4) @(negedge clk);

        // Saturation on the 2-bit counter instance; the 8-bit one reaches 4.
        send(16'hDBA0, 1'b0, 0, W, k1);
        send(16'hD000, 1'b1, 4, W, k2);
        repeat (3) @(negedge clk);
        check("sat_before_4th_cnt", match_cnt_s, 3);
        check("sat_before_4th_flag", cnt_sat_s, 0);
        @(negedge clk);
        check("sat_at_4th_cnt", match_cnt_s, 3);
        check("sat_at_4th_flag", cnt_sat_s, 1);
        repeat (12) @(negedge clk);
        check("sat_done", done_s, 1);
        check("sat_done_cnt", done_cnt_s, 3);
        @(negedge clk);
        check("sat_cleared_flag", cnt_sat_s, 0);
        check("sat_cleared_cnt", match_cnt_s, 0);
        repeat (4) @(negedge clk);

        // Reset while bit 5 is on the core.
        send(16'hDBA0, 1'b1, 0, 6, k1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_checks("midrst");
        rst = 1'b0;
        @(negedge clk);
        send(16'hDBA0, 1'b1, 3, W, k1);
        repeat (W + 4) @(negedge clk);

        // in_valid held across four words: 64 bit cycles, one done.
        rdy_cnt = 0;
        send(16'h000D, 1'b0, 0, W, k1);
        rdy_en = 1'b1;
        send(16'h0000, 1'b0, 0, W, k2);
        send(16'h000D, 1'b0, 0, W, k3);
        send(16'h0000, 1'b1, 2, W, k4);
        check("held_valid_span", k4 - k1, 3 * W);
        repeat (W) @(negedge clk);
        rdy_en = 1'b0;
        check("held_valid_ready_cycles", rdy_cnt, 3);
        repeat (6) @(negedge clk);

        check("match_queue_drained", exp_match_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
